// File: rtl/apb_slave_regs.sv
// APB register bank with fixed wait states, byte strobes, decode errors and protocol checking.
// Register i is exposed flat at reg_flat_out[i*DW +: DW]; xfer_cnt_out counts completed transfers.
module apb_slave_regs #(
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        REG_NUM        = 8,
  parameter int                        WAIT_CYCLES    = 2,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                                apb_clk_in,
  input  logic                                apb_rstn_in,
  input  logic [APB_ADDR_WIDTH-1:0]           apb_addr_in,
  input  logic                                apb_psel_in,
  input  logic                                apb_penable_in,
  input  logic                                apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0]           apb_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0]         apb_strb_in,
  output logic [APB_DATA_WIDTH-1:0]           apb_rdata_out,
  output logic                                apb_ready_out,
  output logic                                apb_slverr_out,
  output logic [REG_NUM*APB_DATA_WIDTH-1:0]   reg_flat_out,
  output logic [15:0]                         xfer_cnt_out,
  output logic                                proto_err_out
);

  localparam int DW    = APB_DATA_WIDTH;
  localparam int AW    = APB_ADDR_WIDTH;
  localparam int BYTES = DW / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [AW-1:0] SPAN      = AW'(REG_NUM * BYTES);
  localparam logic [AW-1:0] ALIGN     = AW'(BYTES - 1);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic                      write_q, write_d;
  logic [DW-1:0]             wdata_q, wdata_d;
  logic [BYTES-1:0]          strb_q, strb_d;
  logic [REG_NUM*DW-1:0]     reg_q, reg_d;
  logic [15:0]               xfer_q, xfer_d;
  logic                      perr_q, perr_d;

  logic [AW-1:0]             off;
  logic [IDX_W-1:0]          idx;
  logic                      dec_err;
  logic                      ready;
  logic                      mismatch;

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      reg_q   <= '0;
      xfer_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      reg_q   <= reg_d;
      xfer_q  <= xfer_d;
      perr_q  <= perr_d;
    end
  end

  // Any drift of the bus away from the latched setup values aborts the access.
  assign mismatch = !apb_psel_in || !apb_penable_in ||
                    (apb_addr_in != addr_q) || (apb_write_in != write_q) ||
                    (apb_strb_in != strb_q) || (write_q && (apb_wdata_in != wdata_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    reg_d   = reg_q;
    xfer_d  = xfer_q;
    perr_d  = perr_q;
    if (state_q == IDLE) begin
      if (apb_psel_in && !apb_penable_in) begin
        addr_d  = apb_addr_in;
        write_d = apb_write_in;
        wdata_d = apb_wdata_in;
        strb_d  = apb_strb_in;
        cnt_d   = '0;
        state_d = ACCESS;
      end else if (apb_psel_in && apb_penable_in) begin
        perr_d = 1'b1;
      end
    end else begin
      if (mismatch) begin
        perr_d  = 1'b1;
        state_d = IDLE;
      end else if (ready) begin
        xfer_d  = xfer_q + 16'd1;
        state_d = IDLE;
        if (write_q && !dec_err) begin
          for (int k = 0; k < BYTES; k++) begin
            if (strb_q[k]) reg_d[int'(idx)*DW + k*8 +: 8] = wdata_q[k*8 +: 8];
          end
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    off            = addr_q - BASE_ADDR;
    idx            = off[LSB +: IDX_W];
    dec_err        = (addr_q < BASE_ADDR) || (off >= SPAN) || ((off & ALIGN) != '0);
    ready          = (state_q == ACCESS) && (cnt_q == WAIT_LAST);
    apb_ready_out  = ready;
    apb_slverr_out = ready && dec_err;
    apb_rdata_out  = '0;
    if (ready && !write_q && !dec_err) apb_rdata_out = reg_q[int'(idx)*DW +: DW];
    reg_flat_out   = reg_q;
    xfer_cnt_out   = xfer_q;
    proto_err_out  = perr_q;
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: transaction-level register model checked every cycle,
// plus a zero-wait instance with a non-zero base used for counter wrap and base decode.
module tb_apb_slave_regs;
  localparam int NREG  = 8;
  localparam int WAITC = 2;

  logic clk = 1'b0;
  logic fclk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  always #2 fclk = ~fclk;

  logic [31:0]  addr, wdata, rdata;
  logic         psel, penable, pwrite, ready, slverr, perr;
  logic [3:0]   strb;
  logic [255:0] reg_flat;
  logic [15:0]  xfer;

  logic [31:0]  f_addr, f_wdata, f_rdata;
  logic         f_psel, f_penable, f_write, f_ready, f_slverr, f_perr;
  logic [3:0]   f_strb;
  logic [255:0] f_reg_flat;
  logic [15:0]  f_xfer;

  apb_slave_regs dut (
    .apb_clk_in(clk), .apb_rstn_in(rstn), .apb_addr_in(addr),
    .apb_psel_in(psel), .apb_penable_in(penable), .apb_write_in(pwrite),
    .apb_wdata_in(wdata), .apb_strb_in(strb), .apb_rdata_out(rdata),
    .apb_ready_out(ready), .apb_slverr_out(slverr), .reg_flat_out(reg_flat),
    .xfer_cnt_out(xfer), .proto_err_out(perr)
  );

  apb_slave_regs #(.WAIT_CYCLES(0), .BASE_ADDR(32'h1000)) u_fast (
    .apb_clk_in(fclk), .apb_rstn_in(rstn), .apb_addr_in(f_addr),
    .apb_psel_in(f_psel), .apb_penable_in(f_penable), .apb_write_in(f_write),
    .apb_wdata_in(f_wdata), .apb_strb_in(f_strb), .apb_rdata_out(f_rdata),
    .apb_ready_out(f_ready), .apb_slverr_out(f_slverr), .reg_flat_out(f_reg_flat),
    .xfer_cnt_out(f_xfer), .proto_err_out(f_perr)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] m_regs [NREG];
  int          m_xfer;
  logic        m_perr;
  logic        m_ready, m_slverr;
  logic [31:0] m_rdata;
  logic        cmp_en = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic dec_err(input logic [31:0] a, input logic [31:0] base);
    return (a < base) || ((a - base) >= NREG * 4) || ((a % 4) != 0);
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < NREG; i++) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_xfer = 0;
    m_perr = 1'b0;
  endtask

  task automatic exp_idle();
    m_ready = 1'b0; m_slverr = 1'b0; m_rdata = '0;
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; addr = '0; wdata = '0; strb = '0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready", ready, m_ready);
      check("slverr", slverr, m_slverr);
      check("rdata", rdata, m_rdata);
      check("reg_flat", reg_flat, model_flat());
      check("xfer_cnt", xfer, m_xfer[15:0]);
      check("proto_err", perr, m_perr);
    end
  end

  // Called one tick after a rising edge; returns one tick after the completing edge.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int ready_at,
                          output logic [31:0] rd, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; addr = a; wdata = d; strb = s;
    exp_idle();
    ready_at = 0; rd = '0; err = 1'b0;
    for (int n = 1; n <= WAITC + 1; n++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (n == WAITC + 1) begin
        m_ready  = 1'b1;
        m_slverr = dec_err(a, 32'h0);
        m_rdata  = (!wr && !m_slverr) ? m_regs[a / 4] : 32'h0;
      end
      @(negedge clk);
      if (ready === 1'b1 && ready_at == 0) begin
        ready_at = n; rd = rdata; err = slverr;
      end
    end
    @(posedge clk); #1;
    if (wr && !dec_err(a, 32'h0))
      for (int k = 0; k < 4; k++) if (s[k]) m_regs[a / 4][k*8 +: 8] = d[k*8 +: 8];
    m_xfer = (m_xfer + 1) % 65536;
    bus_idle();
    exp_idle();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    exp_idle();
    bus_idle();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic fast_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output logic rdy, output logic err, output logic [31:0] rd);
    f_psel = 1'b1; f_penable = 1'b0; f_write = wr; f_addr = a; f_wdata = d; f_strb = 4'hF;
    @(posedge fclk); #1;
    f_penable = 1'b1;
    rdy = f_ready; err = f_slverr; rd = f_rdata;
    @(posedge fclk); #1;
    f_psel = 1'b0; f_penable = 1'b0;
  endtask

  initial begin
    int          at;
    logic [31:0] rd;
    logic        er, frdy;

    bus_idle();
    f_psel = 1'b0; f_penable = 1'b0; f_write = 1'b0; f_addr = '0; f_wdata = '0; f_strb = '0;
    model_reset();
    exp_idle();
    #2 rstn = 1'b0;
    #1;
    check("rst_ready", ready, 0);
    check("rst_slverr", slverr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_regs", reg_flat, 0);
    check("rst_xfer", xfer, 0);
    check("rst_perr", perr, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cmp_en = 1'b1;

    apb_xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, at, rd, er);
    check("wr_ready_cycle", at, 3);
    check("wr_slverr", er, 0);
    check("wr_reg1", reg_flat[63:32], 32'hDEADBEEF);
    check("wr_xfer", xfer, 1);

    apb_xfer(1'b1, 32'h4, 32'h11223344, 4'h5, at, rd, er);
    apb_xfer(1'b0, 32'h4, 32'h0, 4'hF, at, rd, er);
    check("strb_merge_rdata", rd, 32'hDE22BE44);
    check("strb_merge_xfer", xfer, 3);

    apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, at, rd, er);
    check("oor_slverr", er, 1);
    check("oor_rdata", rd, 0);
    check("oor_regs", reg_flat, 256'hDE22BE44 << 32);
    check("oor_xfer", xfer, 4);
    apb_xfer(1'b0, 32'h2, 32'h0, 4'h0, at, rd, er);
    check("misalign_slverr", er, 1);
    check("misalign_xfer", xfer, 5);

    apb_xfer(1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, at, rd, er);
    check("errwr_slverr", er, 1);
    apb_xfer(1'b1, 32'h5, 32'hFFFFFFFF, 4'hF, at, rd, er);
    check("errwr_regs", reg_flat, 256'hDE22BE44 << 32);
    check("errwr_xfer", xfer, 7);

    apb_xfer(1'b1, 32'h8, 32'h12345678, 4'h0, at, rd, er);
    check("strb0_slverr", er, 0);
    check("strb0_reg2", reg_flat[95:64], 0);

    apb_xfer(1'b1, 32'h1C, 32'h0BADF00D, 4'hF, at, rd, er);
    apb_xfer(1'b0, 32'h1C, 32'h0, 4'h0, at, rd, er);
    check("reg7_rdata", rd, 32'h0BADF00D);
    apb_xfer(1'b1, 32'h0, 32'hCAFEBABE, 4'hA, at, rd, er);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h3, at, rd, er);
    check("reg0_partial", rd, 32'hCA00BA00);
    check("b2b_xfer", xfer, 12);

    // Protocol violation: PENABLE dropped in the second access cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = 32'h8; wdata = 32'h55AA55AA; strb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 penable = 1'b0;
    @(posedge clk); #1;
    m_perr = 1'b1;
    bus_idle();
    check("drop_perr", perr, 1);
    check("drop_reg2", reg_flat[95:64], 0);
    check("drop_xfer", xfer, 12);

    do_reset();
    check("clr_perr", perr, 0);
    // Protocol violation: access phase with no setup phase.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; addr = 32'hC; wdata = 32'h77777777; strb = 4'hF;
    @(posedge clk); #1;
    m_perr = 1'b1;
    bus_idle();
    check("nosetup_perr", perr, 1);
    check("nosetup_regs", reg_flat, 0);
    check("nosetup_xfer", xfer, 0);

    // Asynchronous reset while a read sits in its ready cycle.
    apb_xfer(1'b1, 32'hC, 32'hA5A55A5A, 4'hF, at, rd, er);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; addr = 32'hC; strb = 4'h0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_ready = 1'b1; m_rdata = 32'hA5A55A5A;
    #1;
    check("pre_rst_ready", ready, 1);
    check("pre_rst_rdata", rdata, 32'hA5A55A5A);
    rstn = 1'b0;
    model_reset();
    exp_idle();
    #1;
    check("async_ready", ready, 0);
    check("async_slverr", slverr, 0);
    check("async_rdata", rdata, 0);
    check("async_regs", reg_flat, 0);
    check("async_xfer", xfer, 0);
    check("async_perr", perr, 0);
    bus_idle();
    @(posedge clk); #1;
    rstn = 1'b1;
    apb_xfer(1'b1, 32'h14, 32'h00C0FFEE, 4'hF, at, rd, er);
    check("post_rst_xfer", xfer, 1);
    check("post_rst_regs", reg_flat, 256'h00C0FFEE << 160);
    cmp_en = 1'b0;

    @(posedge fclk); #1;
    check("fast_xfer_init", f_xfer, 0);
    for (int i = 0; i < 65535; i++)
      fast_xfer(1'b1, 32'h1000 + (i % 8) * 4, i, frdy, er, rd);
    check("fast_xfer_ffff", f_xfer, 16'hFFFF);
    check("fast_reg0", f_reg_flat[31:0], 32'h0000FFF8);
    fast_xfer(1'b0, 32'h0FFC, 32'h0, frdy, er, rd);
    check("fast_ready_first", frdy, 1);
    check("below_base_slverr", er, 1);
    check("below_base_rdata", rd, 0);
    check("fast_xfer_wrap", f_xfer, 16'h0000);
    fast_xfer(1'b0, 32'h1004, 32'h0, frdy, er, rd);
    check("fast_reg1_rdata", rd, 32'h0000FFF9);
    check("fast_reg1_slverr", er, 0);
    check("fast_perr", f_perr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
